plot_frame_reader: RTL

Receiving end of the snake drawing core's plot interface. Captures every `VGA_write` pixel store (`VGA_x`, `VGA_y`, `VGA_color`) into an on-chip 160x120 frame store. On request, it streams the whole frame back out in raster order over a valid/ready pixel port. Simulation benches use it to dump and check whole frames. On hardware it serves as a shadow frame for the score and collision debug logic.

---
 rtl/plot_frame_reader_if.sv | 53 +++++
 rtl/plot_frame_reader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_frame_reader_if.sv
// -----------------------------------------------------------------------------
// plot_frame_reader_if
//
// Groups the two buses of the plot frame reader into one interface:
//   * plot bus   : VGA_x / VGA_y / VGA_color / VGA_write, driven by the drawing
//                  core, one pixel store per cycle that VGA_write is high.
//   * dump bus   : frame_req starts a raster-order dump; pix_x / pix_y /
//                  pix_color / pix_valid present one stored pixel at a time and
//                  pix_ready accepts it; frame_done pulses after the last pixel.
//   * status     : busy (clearing or dumping) and drop_count (rejected stores).
//
// Modports:
//   master : the side that plots pixels and consumes the dump (core / bench).
//   slave  : the frame reader itself.
// -----------------------------------------------------------------------------
interface plot_frame_reader_if #(
  parameter int CW = 9
);

  // Plot bus
  logic [7:0]    VGA_x;
  logic [6:0]    VGA_y;
  logic [CW-1:0] VGA_color;
  logic          VGA_write;

  // Dump request and pixel stream
  logic          frame_req;
  logic [7:0]    pix_x;
  logic [6:0]    pix_y;
  logic [CW-1:0] pix_color;
  logic          pix_valid;
  logic          pix_ready;
  logic          frame_done;

  // Status
  logic          busy;
  logic [15:0]   drop_count;

  modport master (
    output VGA_x, VGA_y, VGA_color, VGA_write,
    output frame_req, pix_ready,
    input  pix_x, pix_y, pix_color, pix_valid, frame_done,
    input  busy, drop_count
  );

  modport slave (
    input  VGA_x, VGA_y, VGA_color, VGA_write,
    input  frame_req, pix_ready,
    output pix_x, pix_y, pix_color, pix_valid, frame_done,
    output busy, drop_count
  );

endinterface

// File: rtl/plot_frame_reader.sv
// -----------------------------------------------------------------------------
// plot_frame_reader
//
// Shadow frame store for the snake drawing core. Every accepted plot store
// (VGA_x, VGA_y, VGA_color while VGA_write is high) is written into a
// WIDTH x HEIGHT single-port RAM. On frame_req the whole frame is streamed
// back in raster order over a valid/ready pixel port.
//
// Ports:
//   CLOCK_50 : sole clock, all logic on its rising edge
//   reset    : synchronous, active-high; restarts the clear sweep
//   bus      : plot_frame_reader_if.slave
//                VGA_x/VGA_y/VGA_color/VGA_write  plot stores in
//                frame_req                        start a dump (IDLE only)
//                pix_x/pix_y/pix_color/pix_valid  presented pixel out
//                pix_ready                        consumer accepts pixel
//                frame_done                       pulse after last pixel
//                busy                             CLEAR, READ or HOLD
//                drop_count                       rejected stores, saturating
//
// States:
//   CLEAR : sweep CLEAR_COLOR over every address, one per cycle
//   IDLE  : plot stores only; frame_req loads scan position (0,0)
//   READ  : issue the RAM read of the scan address unless a plot store
//           wants the port this cycle (the store always wins)
//   HOLD  : present the read pixel until handshake, then advance or finish
//
// The RAM has a single port with a registered read. Because the read register
// only loads on a read issue, stores made while a pixel is held never disturb
// the presented colour, and stores behind the scan position never appear in
// the dump in progress.
// -----------------------------------------------------------------------------
module plot_frame_reader #(
  parameter int            WIDTH       = 160,
  parameter int            HEIGHT      = 120,
  parameter int            CW          = 9,
  parameter logic [CW-1:0] CLEAR_COLOR = '0
) (
  input logic                CLOCK_50,
  input logic                reset,
  plot_frame_reader_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Geometry
  // ---------------------------------------------------------------------------
  localparam int             DEPTH     = WIDTH * HEIGHT;
  localparam int             AW        = 15;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [7:0]     X_LIMIT   = 8'(WIDTH);
  localparam logic [6:0]     Y_LIMIT   = 7'(HEIGHT);
  localparam logic [7:0]     X_LAST    = 8'(WIDTH - 1);
  localparam logic [6:0]     Y_LAST    = 7'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_READ  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Row-major address y*160 + x built from two shifts and an add, so no
  // multiplier is needed. This form is tied to a 160-pixel row.
  function automatic logic [AW-1:0] pix_addr(input logic [7:0] x,
                                             input logic [6:0] y);
    return (AW'(y) << 7) + (AW'(y) << 5) + AW'(x);
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t        r_state;
  logic [AW-1:0] r_clr_addr;
  logic [7:0]    r_scan_x;
  logic [6:0]    r_scan_y;
  logic [CW-1:0] r_rd_data;
  logic          r_frame_done;
  logic [15:0]   r_drop_count;
  logic [CW-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t        w_state_next;
  logic          w_plot_in_range;
  logic          w_plot_ok;
  logic          w_plot_drop;
  logic          w_scan_last;
  logic          w_rd_issue;
  logic          w_scan_load;
  logic          w_scan_adv;
  logic          w_last_hs;
  logic          w_mem_we;
  logic          w_mem_re;
  logic [AW-1:0] w_mem_addr;
  logic [CW-1:0] w_mem_wdata;
  logic [AW-1:0] w_plot_addr;
  logic [AW-1:0] w_scan_addr;

  assign w_plot_addr     = pix_addr(bus.VGA_x, bus.VGA_y);
  assign w_scan_addr     = pix_addr(r_scan_x, r_scan_y);
  assign w_plot_in_range = (bus.VGA_x < X_LIMIT) && (bus.VGA_y < Y_LIMIT);

  // A store is accepted only in range and outside the clear sweep; anything
  // else strobed on VGA_write is counted as dropped.
  assign w_plot_ok   = bus.VGA_write && w_plot_in_range && (r_state != S_CLEAR);
  assign w_plot_drop = bus.VGA_write && !w_plot_ok;

  assign w_scan_last = (r_scan_x == X_LAST) && (r_scan_y == Y_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_rd_issue   = 1'b0;
    w_scan_load  = 1'b0;
    w_scan_adv   = 1'b0;
    w_last_hs    = 1'b0;

    case (r_state)
      S_CLEAR: begin
        if (r_clr_addr == LAST_ADDR) begin
          w_state_next = S_IDLE;
        end
      end

      S_IDLE: begin
        if (bus.frame_req) begin
          w_scan_load  = 1'b1;
          w_state_next = S_READ;
        end
      end

      S_READ: begin
        // A plot strobe owns the single RAM port; the read waits a cycle.
        if (!bus.VGA_write) begin
          w_rd_issue   = 1'b1;
          w_state_next = S_HOLD;
        end
      end

      S_HOLD: begin
        if (bus.pix_ready) begin
          if (w_scan_last) begin
            w_last_hs    = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_scan_adv   = 1'b1;
            w_state_next = S_READ;
          end
        end
      end

      default: begin
        w_state_next = S_CLEAR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // RAM port arbitration: clear sweep, then plot store, then dump read.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_mem_addr  = w_plot_addr;
    w_mem_wdata = bus.VGA_color;

    if (r_state == S_CLEAR) begin
      w_mem_we    = !reset;
      w_mem_addr  = r_clr_addr;
      w_mem_wdata = CLEAR_COLOR;
    end else if (w_plot_ok) begin
      w_mem_we    = !reset;
    end else if (w_rd_issue) begin
      w_mem_re    = 1'b1;
      w_mem_addr  = w_scan_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame store
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; it maps onto block RAM, and the
  // clear sweep is what gives it a known content after reset.
  always_ff @(posedge CLOCK_50) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Read register loads only on a read issue, so it holds the presented
  // pixel through any number of HOLD cycles and concurrent stores.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (w_mem_re) begin
      r_rd_data <= r_mem[w_mem_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Clear counter, scan position, done pulse, drop counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_clr_addr   <= '0;
      r_scan_x     <= '0;
      r_scan_y     <= '0;
      r_frame_done <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (r_state == S_CLEAR) begin
        r_clr_addr <= r_clr_addr + AW'(1);
      end

      if (w_scan_load) begin
        r_scan_x <= '0;
        r_scan_y <= '0;
      end else if (w_scan_adv) begin
        if (r_scan_x == X_LAST) begin
          r_scan_x <= '0;
          r_scan_y <= r_scan_y + 7'd1;
        end else begin
          r_scan_x <= r_scan_x + 8'd1;
        end
      end

      r_frame_done <= w_last_hs;

      if (w_plot_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.pix_x      = r_scan_x;
  assign bus.pix_y      = r_scan_y;
  assign bus.pix_color  = r_rd_data;
  assign bus.pix_valid  = (r_state == S_HOLD);
  assign bus.frame_done = r_frame_done;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.drop_count = r_drop_count;

endmodule
